// File: rtl/his_acq_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the SiFH histogram acquisition sequencer.
// Default sizes match the production pixel array; the top-level parameters override them.
package his_acq_sequencer_pkg;

    localparam int DATA_NUM_DEF      = 2;
    localparam int PIXEL_NUM_PER_RAM = 200;
    localparam int ACQ_NUM_DEF       = 33333;
    localparam int NB_DEF            = 12;
    localparam int BIN_NUM_PER_RAM   = 4096;

    localparam int IN_W   = 2;
    localparam int PIX_W  = 8;
    localparam int ACQ_W  = 20;
    localparam int DROP_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACQ     = 3'd2,
        S_SWAP    = 3'd3,
        S_WAIT_RD = 3'd4
    } state_t;

    // Per-level "counter sits at its last value" flags of the nested event counter.
    typedef struct packed {
        logic in_max;
        logic pix_max;
        logic acq_max;
    } cnt_max_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/his_acq_sequencer_nested_counter.sv
// Three-level event/pixel/acquisition counter. Advances on en, clears synchronously,
// and reports which levels are at their terminal value so the caller can detect wraps.
module his_nested_counter
    import his_acq_sequencer_pkg::*;
#(
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int PIXEL_NUM = PIXEL_NUM_PER_RAM,
    parameter int ACQ_NUM   = ACQ_NUM_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             clr,
    output logic [PIX_W-1:0] pix_cnt,
    output cnt_max_t         at_max
);

    logic [IN_W-1:0]  in_cnt;
    logic [ACQ_W-1:0] acq_cnt;

    assign at_max.in_max  = (in_cnt  == IN_W'(DATA_NUM - 1));
    assign at_max.pix_max = (pix_cnt == PIX_W'(PIXEL_NUM - 1));
    assign at_max.acq_max = (acq_cnt == ACQ_W'(ACQ_NUM - 1));

    always_ff @(posedge clk) begin
        if (!res || clr) begin
            in_cnt  <= '0;
            pix_cnt <= '0;
            acq_cnt <= '0;
        end else if (en) begin
            if (at_max.in_max) begin
                in_cnt <= '0;
                if (at_max.pix_max) begin
                    pix_cnt <= '0;
                    acq_cnt <= at_max.acq_max ? '0 : acq_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end else begin
                in_cnt <= in_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/his_acq_sequencer.sv
// Sequencer for the SiFH histogram builder: clears a bank, fills it from TDC events,
// then ping-pongs banks and offers the finished one to readout with a req/ack handshake.
module his_acq_sequencer
    import his_acq_sequencer_pkg::*;
#(
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int PIXEL_NUM = PIXEL_NUM_PER_RAM,
    parameter int ACQ_NUM   = ACQ_NUM_DEF,
    parameter int NB        = NB_DEF,
    parameter int BIN_NUM   = BIN_NUM_PER_RAM
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              stop,
    input  logic              tdc_valid,
    input  logic [NB-1:0]     tdc_addr,
    output logic              wr_en,
    output logic [NB-1:0]     wr_addr,
    output logic [PIX_W-1:0]  wr_pixel,
    output logic              his_num,
    output logic              clr_en,
    output logic [NB-1:0]     clr_addr,
    output logic              rd_req,
    output logic              rd_bank,
    input  logic              rd_ack,
    output logic              frame_done,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    state_t           state, state_nxt;
    logic [NB-1:0]    clr_cnt;
    logic [PIX_W-1:0] pix_cnt;
    cnt_max_t         cnt_max;

    logic acq_evt, frame_last, clr_last, start_ok, rd_pending, drop_state;

    assign acq_evt    = (state == S_ACQ) && tdc_valid;
    assign frame_last = acq_evt && cnt_max.in_max && cnt_max.pix_max && cnt_max.acq_max;
    assign clr_last   = (clr_cnt == NB'(BIN_NUM - 1));
    assign start_ok   = (state == S_IDLE) && start;
    // An ack arriving in SWAP retires the old request, so the bank about to be cleared is free.
    assign rd_pending = rd_req && !rd_ack;
    assign drop_state = (state == S_CLEAR) || (state == S_SWAP) || (state == S_WAIT_RD);

    assign busy     = (state != S_IDLE);
    assign clr_en   = (state == S_CLEAR);
    assign clr_addr = clr_cnt;

    his_nested_counter #(
        .DATA_NUM  (DATA_NUM),
        .PIXEL_NUM (PIXEL_NUM),
        .ACQ_NUM   (ACQ_NUM)
    ) u_cnt (
        .clk     (clk),
        .res     (res),
        .en      (acq_evt),
        .clr     ((state == S_SWAP) || start_ok),
        .pix_cnt (pix_cnt),
        .at_max  (cnt_max)
    );

    always_ff @(posedge clk) begin
        if (!res) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CLEAR;
            S_CLEAR:   if (clr_last) state_nxt = S_ACQ;
            S_ACQ:     if (frame_last) state_nxt = S_SWAP;
            S_SWAP: begin
                if (rd_pending) state_nxt = S_WAIT_RD;
                else if (stop)  state_nxt = S_IDLE;
                else            state_nxt = S_CLEAR;
            end
            S_WAIT_RD: if (rd_ack) state_nxt = stop ? S_IDLE : S_CLEAR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res)                          clr_cnt <= '0;
        else if (clr_en && !clr_last)      clr_cnt <= clr_cnt + 1'b1;
        else                               clr_cnt <= '0;
    end

    // Write port carries the event one cycle later; his_num only moves after SWAP,
    // so it still names the bank of the last event while that write is out.
    always_ff @(posedge clk) begin
        if (!res) begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            wr_addr    <= '0;
            wr_pixel   <= '0;
        end else begin
            wr_en      <= acq_evt;
            frame_done <= frame_last;
            if (acq_evt) begin
                wr_addr  <= tdc_addr;
                wr_pixel <= pix_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            his_num <= 1'b0;
            rd_req  <= 1'b0;
            rd_bank <= 1'b0;
        end else if (state == S_SWAP) begin
            his_num <= ~his_num;
            rd_req  <= 1'b1;
            rd_bank <= his_num;
        end else if (rd_ack) begin
            rd_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!res)                          drop_cnt <= '0;
        else if (start_ok)                 drop_cnt <= '0;
        else if (tdc_valid && drop_state)  drop_cnt <= sat_inc(drop_cnt);
    end

endmodule
